regfile_mp: RTL and testbench

Parametrised multi-port register file for the core's integer datapath. It provides NUM_RD registered read ports and NUM_WR write ports with active-low enables. Register 0 can be configured as hardwired zero. Same-cycle write-to-read bypass is built in, along with a per-register busy scoreboard that the issue stage uses to detect pending writebacks.

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file with registered read ports,
//             same-cycle write-to-read bypass, optional hardwired-zero x0 and
//             a per-register busy scoreboard for pending writebacks.
//  Ports    : clk      - clock, all state updates on the rising edge
//             rstL     - asynchronous active-low reset
//             rd_addr  - NUM_RD read indices (ADDR_W bits each)
//             rd_data  - NUM_RD registered read values (WORD_SIZE bits each)
//             rd_busy  - NUM_RD registered busy flags of the addressed regs
//             wr_enL   - NUM_WR active-low write enables
//             wr_addr  - NUM_WR write indices
//             wr_data  - NUM_WR write values
//             rsv_enL  - active-low reserve strobe (marks rsv_addr busy)
//             rsv_addr - register index to reserve
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rstL,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]      rd_addr,
    output logic [NUM_RD-1:0][WORD_SIZE-1:0]   rd_data,
    output logic [NUM_RD-1:0]                  rd_busy,
    input  logic [NUM_WR-1:0]                  wr_enL,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]      wr_addr,
    input  logic [NUM_WR-1:0][WORD_SIZE-1:0]   wr_data,
    input  logic                               rsv_enL,
    input  logic [ADDR_W-1:0]                  rsv_addr
);

    // With a hardwired-zero x0, register 0 is skipped by every decode loop:
    // it is never written, never busy, and a read of it falls through to 0.
    localparam int c_FIRST_REG = (ZERO_REG != 0) ? 1 : 0;

    logic [WORD_SIZE-1:0]              r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]               r_busy;
    logic [NUM_RD-1:0][WORD_SIZE-1:0]  r_rd_data;
    logic [NUM_RD-1:0]                 r_rd_busy;

    logic [NUM_REGS-1:0]               w_wr_hit;
    logic [WORD_SIZE-1:0]              w_wr_val [NUM_REGS];
    logic [NUM_REGS-1:0]               w_busy_next;
    logic [NUM_RD-1:0][WORD_SIZE-1:0]  w_rd_data;
    logic [NUM_RD-1:0]                 w_rd_busy;

    // Per-register write resolution. Ports are scanned in ascending order so
    // the highest-numbered enabled port targeting a register wins. Indices
    // at or above NUM_REGS never match any register and are dropped.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_val[i] = '0;
        end
        for (int i = c_FIRST_REG; i < NUM_REGS; i++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (!wr_enL[p] && (wr_addr[p] == ADDR_W'(i))) begin
                    w_wr_hit[i] = 1'b1;
                    w_wr_val[i] = wr_data[p];
                end
            end
        end
    end

    // A writeback clears the busy bit, but a same-cycle reserve re-sets it:
    // the newly issued producer supersedes the one that is retiring.
    always_comb begin
        w_busy_next = '0;
        for (int i = c_FIRST_REG; i < NUM_REGS; i++) begin
            w_busy_next[i] = (r_busy[i] & ~w_wr_hit[i])
                           | (!rsv_enL && (rsv_addr == ADDR_W'(i)));
        end
    end

    // Read muxes. Data is bypassed from the winning same-cycle write and the
    // busy flag is taken from busy_next, so both reflect the state that will
    // exist after this edge. Unmatched (out-of-range or zero) reads give 0.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int i = c_FIRST_REG; i < NUM_REGS; i++) begin
                if (rd_addr[r] == ADDR_W'(i)) begin
                    w_rd_data[r] = w_wr_hit[i] ? w_wr_val[i] : r_regs[i];
                    w_rd_busy[r] = w_busy_next[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy    <= '0;
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= w_wr_val[i];
                end
            end
            r_busy    <= w_busy_next;
            r_rd_data <= w_rd_data;
            r_rd_busy <= w_rd_busy;
        end
    end

    assign rd_data = r_rd_data;
    assign rd_busy = r_rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Three configurations run in
//             lockstep: default-width with zero x0, 64-bit/16-reg/3-read with
//             writable x0, and a 6-reg file whose upper indices are invalid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstL;
    int   checks = 0;
    int   errors = 0;

    // Stimulus, one slot per configuration, sized for the widest one.
    logic        s_wenL  [3][2];
    logic [4:0]  s_waddr [3][2];
    logic [63:0] s_wdata [3][2];
    logic [4:0]  s_raddr [3][3];
    logic        s_rsvL  [3];
    logic [4:0]  s_rsva  [3];

    // Observed outputs, zero-extended.
    logic [63:0] o_data [3][3];
    logic        o_busy [3][3];

    logic [1:0]       d0_wr_enL;
    logic [1:0][4:0]  d0_wr_addr;
    logic [1:0][31:0] d0_wr_data;
    logic [1:0][4:0]  d0_rd_addr;
    logic [1:0][31:0] d0_rd_data;
    logic [1:0]       d0_rd_busy;

    logic [1:0]       d1_wr_enL;
    logic [1:0][3:0]  d1_wr_addr;
    logic [1:0][63:0] d1_wr_data;
    logic [2:0][3:0]  d1_rd_addr;
    logic [2:0][63:0] d1_rd_data;
    logic [2:0]       d1_rd_busy;

    logic [1:0]       d2_wr_enL;
    logic [1:0][2:0]  d2_wr_addr;
    logic [1:0][7:0]  d2_wr_data;
    logic [1:0][2:0]  d2_rd_addr;
    logic [1:0][7:0]  d2_rd_data;
    logic [1:0]       d2_rd_busy;

    logic [3:0] d1_rsv_addr;
    logic [2:0] d2_rsv_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            d0_wr_enL[p]  = s_wenL[0][p];
            d0_wr_addr[p] = s_waddr[0][p];
            d0_wr_data[p] = s_wdata[0][p][31:0];
            d1_wr_enL[p]  = s_wenL[1][p];
            d1_wr_addr[p] = s_waddr[1][p][3:0];
            d1_wr_data[p] = s_wdata[1][p];
            d2_wr_enL[p]  = s_wenL[2][p];
            d2_wr_addr[p] = s_waddr[2][p][2:0];
            d2_wr_data[p] = s_wdata[2][p][7:0];
            d0_rd_addr[p] = s_raddr[0][p];
            d2_rd_addr[p] = s_raddr[2][p][2:0];
        end
        for (int r = 0; r < 3; r++) begin
            d1_rd_addr[r] = s_raddr[1][r][3:0];
        end
        d1_rsv_addr = s_rsva[1][3:0];
        d2_rsv_addr = s_rsva[2][2:0];
    end

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 3; r++) begin
                o_data[d][r] = '0;
                o_busy[d][r] = 1'b0;
            end
        end
        for (int r = 0; r < 2; r++) begin
            o_data[0][r] = 64'(d0_rd_data[r]);
            o_busy[0][r] = d0_rd_busy[r];
            o_data[2][r] = 64'(d2_rd_data[r]);
            o_busy[2][r] = d2_rd_busy[r];
        end
        for (int r = 0; r < 3; r++) begin
            o_data[1][r] = d1_rd_data[r];
            o_busy[1][r] = d1_rd_busy[r];
        end
    end

    regfile_mp #(.WORD_SIZE(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_dut0 (
        .clk(clk), .rstL(rstL),
        .rd_addr(d0_rd_addr), .rd_data(d0_rd_data), .rd_busy(d0_rd_busy),
        .wr_enL(d0_wr_enL), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
        .rsv_enL(s_rsvL[0]), .rsv_addr(s_rsva[0])
    );

    regfile_mp #(.WORD_SIZE(64), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(0)) u_dut1 (
        .clk(clk), .rstL(rstL),
        .rd_addr(d1_rd_addr), .rd_data(d1_rd_data), .rd_busy(d1_rd_busy),
        .wr_enL(d1_wr_enL), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
        .rsv_enL(s_rsvL[1]), .rsv_addr(d1_rsv_addr)
    );

    regfile_mp #(.WORD_SIZE(8), .NUM_REGS(6), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rstL(rstL),
        .rd_addr(d2_rd_addr), .rd_data(d2_rd_data), .rd_busy(d2_rd_busy),
        .wr_enL(d2_wr_enL), .wr_addr(d2_wr_addr), .wr_data(d2_wr_data),
        .rsv_enL(s_rsvL[2]), .rsv_addr(d2_rsv_addr)
    );

    // ---------------- configuration table ----------------
    function automatic int nregs(int d);
        case (d) 0: return 32; 1: return 16; default: return 6; endcase
    endfunction
    function automatic int nrd(int d);
        return (d == 1) ? 3 : 2;
    endfunction
    function automatic bit zero(int d);
        return (d != 1);
    endfunction
    function automatic int width(int d);
        case (d) 0: return 32; 1: return 64; default: return 8; endcase
    endfunction
    function automatic int awid(int d);
        case (d) 0: return 5; 1: return 4; default: return 3; endcase
    endfunction
    function automatic logic [63:0] msk(int d);
        return (width(d) == 64) ? '1 : ((64'd1 << width(d)) - 64'd1);
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] m_regs [3][32];
    logic        m_busy [3][32];

    function automatic bit valid_reg(int d, int a);
        return (a < nregs(d)) && !(zero(d) && a == 0);
    endfunction

    // Effective write this cycle to register a: last enabled port listed wins.
    function automatic void win(input int d, input int a, output logic hit, output logic [63:0] val);
        hit = 1'b0;
        val = '0;
        if (!valid_reg(d, a)) return;
        for (int p = 0; p < 2; p++) begin
            if (!s_wenL[d][p] && int'(s_waddr[d][p]) == a) begin
                hit = 1'b1;
                val = s_wdata[d][p] & msk(d);
            end
        end
    endfunction

    function automatic logic [63:0] exp_data(int d, int a);
        logic h;
        logic [63:0] v;
        if (!valid_reg(d, a)) return '0;
        win(d, a, h, v);
        return h ? v : m_regs[d][a];
    endfunction

    function automatic logic exp_busy(int d, int a);
        logic h;
        logic [63:0] v;
        if (!valid_reg(d, a)) return 1'b0;
        if (!s_rsvL[d] && int'(s_rsva[d]) == a) return 1'b1;
        win(d, a, h, v);
        return m_busy[d][a] && !h;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[d][i] = '0;
                m_busy[d][i] = 1'b0;
            end
        end
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs and next state from the current inputs,
    // cross the edge, compare every read port, then commit the model.
    task automatic step();
        logic [63:0] ed [3][3];
        logic        eb [3][3];
        logic [63:0] nr [3][32];
        logic        nb [3][32];
        logic        h;
        logic [63:0] v;
        nr = m_regs;
        nb = m_busy;
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 3; r++) begin
                ed[d][r] = exp_data(d, int'(s_raddr[d][r]));
                eb[d][r] = exp_busy(d, int'(s_raddr[d][r]));
            end
            for (int i = 0; i < nregs(d); i++) begin
                win(d, i, h, v);
                if (h) nr[d][i] = v;
                nb[d][i] = exp_busy(d, i);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < nrd(d); r++) begin
                check($sformatf("d%0d_rd%0d_data", d, r), o_data[d][r], ed[d][r]);
                check($sformatf("d%0d_rd%0d_busy", d, r), 64'(o_busy[d][r]), 64'(eb[d][r]));
            end
        end
        m_regs = nr;
        m_busy = nb;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) s_wenL[d][p] = 1'b1;
            s_rsvL[d] = 1'b1;
        end
    endtask
    task automatic wr(int d, int p, int a, logic [63:0] x);
        s_wenL[d][p]  = 1'b0;
        s_waddr[d][p] = 5'(a);
        s_wdata[d][p] = x;
    endtask
    task automatic rd(int d, int r, int a);
        s_raddr[d][r] = 5'(a);
    endtask
    task automatic rsv(int d, int a);
        s_rsvL[d] = 1'b0;
        s_rsva[d] = 5'(a);
    endtask
    function automatic int raddr(int d);
        if ($urandom_range(0, 1) != 0) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, (1 << awid(d)) - 1));
    endfunction

    // Reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic do_reset(string tag);
        @(negedge clk);
        rstL = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < nrd(d); r++) begin
                check({tag, "_data"}, o_data[d][r], 64'd0);
                check({tag, "_busy"}, 64'(o_busy[d][r]), 64'd0);
            end
        end
        clear_model();
        @(posedge clk);
        #1;
        @(negedge clk);
        rstL = 1'b1;
    endtask

    initial begin
        rstL = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                s_waddr[d][p] = '0;
                s_wdata[d][p] = '0;
            end
            for (int r = 0; r < 3; r++) s_raddr[d][r] = '0;
            s_rsva[d] = '0;
        end
        idle();
        clear_model();
        do_reset("rst_init");

        // Hardwired zero on d0/d2, writable x0 on d1.
        idle();
        wr(0, 0, 0, 64'hDEADBEEF); rd(0, 0, 0);
        wr(1, 0, 0, 64'h5);        rd(1, 0, 0);
        step();
        check("x0_zero_data", o_data[0][0], 64'd0);
        check("x0_zero_busy", 64'(o_busy[0][0]), 64'd0);
        check("x0_sticks", o_data[1][0], 64'h5);
        idle();
        rsv(0, 0); rsv(1, 0);
        step();
        check("x0_zero_rsv_busy", 64'(o_busy[0][0]), 64'd0);
        check("x0_rsv_busy", 64'(o_busy[1][0]), 64'd1);
        idle();
        step();
        check("x0_zero_hold", o_data[0][0], 64'd0);
        check("x0_hold", o_data[1][0], 64'h5);

        // Basic write and bypass.
        idle();
        for (int d = 0; d < 2; d++) begin wr(d, 0, 5, 64'h12345678); rd(d, 0, 5); end
        step();
        check("bypass_d0", o_data[0][0], 64'h12345678);
        check("bypass_d1", o_data[1][0], 64'h12345678);
        idle();
        step();
        for (int d = 0; d < 2; d++) rd(d, 1, 5);
        step();
        check("readback_d0", o_data[0][1], 64'h12345678);
        check("readback_d1", o_data[1][1], 64'h12345678);

        // Two ports writing the same register.
        idle();
        for (int d = 0; d < 2; d++) begin wr(d, 0, 7, 64'h1); wr(d, 1, 7, 64'h2); rd(d, 0, 7); end
        step();
        check("conflict_bypass_d0", o_data[0][0], 64'h2);
        check("conflict_bypass_d1", o_data[1][0], 64'h2);
        idle();
        for (int d = 0; d < 2; d++) rd(d, 1, 7);
        step();
        check("conflict_read_d0", o_data[0][1], 64'h2);
        check("conflict_read_d1", o_data[1][1], 64'h2);

        // Scoreboard lifecycle on x3.
        idle();
        for (int d = 0; d < 2; d++) begin rsv(d, 3); rd(d, 0, 9); end
        step();
        idle();
        for (int d = 0; d < 2; d++) rd(d, 0, 3);
        step();
        check("rsv_busy_d0", 64'(o_busy[0][0]), 64'd1);
        check("rsv_busy_d1", 64'(o_busy[1][0]), 64'd1);
        idle();
        for (int d = 0; d < 2; d++) wr(d, 0, 3, 64'hAA);
        step();
        check("wb_data_d0", o_data[0][0], 64'hAA);
        check("wb_busy_d0", 64'(o_busy[0][0]), 64'd0);
        check("wb_busy_d1", 64'(o_busy[1][0]), 64'd0);
        idle();
        for (int d = 0; d < 2; d++) begin rsv(d, 3); wr(d, 0, 3, 64'hBB); end
        step();
        check("rsv_wr_data_d0", o_data[0][0], 64'hBB);
        check("rsv_wr_busy_d0", 64'(o_busy[0][0]), 64'd1);
        check("rsv_wr_busy_d1", 64'(o_busy[1][0]), 64'd1);
        idle();
        for (int d = 0; d < 2; d++) rsv(d, 3);
        step();
        check("rsv_again_busy_d0", 64'(o_busy[0][0]), 64'd1);

        // Indices past the end of a 6-register file.
        idle();
        wr(2, 0, 6, 64'h11); wr(2, 1, 7, 64'h22); rsv(2, 7);
        rd(2, 0, 6); rd(2, 1, 7);
        step();
        check("oor_data6", o_data[2][0], 64'd0);
        check("oor_data7", o_data[2][1], 64'd0);
        check("oor_busy7", 64'(o_busy[2][1]), 64'd0);

        // Reset mid-run discards state and a pending write.
        idle();
        wr(0, 0, 9, 64'h99); rsv(0, 4);
        rd(0, 0, 5); rd(0, 1, 3);
        do_reset("rst_mid");
        idle();
        rd(0, 0, 9); rd(0, 1, 3);
        step();
        check("rst_drop_wr", o_data[0][0], 64'd0);
        check("rst_clr_busy", 64'(o_busy[0][1]), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if ($urandom_range(0, 2) != 0) wr(d, p, raddr(d), {$urandom, $urandom});
                end
                if ($urandom_range(0, 2) == 0) rsv(d, raddr(d));
                for (int r = 0; r < nrd(d); r++) rd(d, r, raddr(d));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
